regfile_2r1w_sweep: RTL and testbench

- Parametrised successor to the team's 8x8 register file: one write port, two independent read ports.
- Reads are registered, with write-first bypass.
- Adds a hardware sweep-clear sequencer. It zeroes the array one entry per cycle without asserting the global reset.
- Sits between datapath control and the ALU/display mux wherever more than one operand must be read per cycle.

---
 rtl/regfile_2r1w_sweep_if.sv | 28 ++
 rtl/regfile_2r1w_sweep.sv | 95 +++++++++
 tb/tb_regfile_2r1w_sweep.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_sweep_if.sv
// rtl/regfile_2r1w_sweep_if.sv - write/read/sweep signal bundle for regfile_2r1w_sweep
interface regfile_2r1w_sweep_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re_a;
  logic [AW-1:0] raddr_a;
  logic [DW-1:0] rdata_a;
  logic          re_b;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_b;
  logic          init_req;
  logic          busy;
  logic          wr_drop;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, init_req,
    input  rdata_a, rdata_b, busy, wr_drop
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, init_req,
    output rdata_a, rdata_b, busy, wr_drop
  );
endinterface

// File: rtl/regfile_2r1w_sweep.sv
// rtl/regfile_2r1w_sweep.sv - 2-read/1-write register file with write-first bypass and sweep-clear
// Optional REGFILE_ZERO_REG0_EN: entry 0 hardwired to zero, writes to it silently discarded.
module regfile_2r1w_sweep #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic                   clk,
  input  logic                   clr,
  regfile_2r1w_sweep_if.slave    bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          wr_drop_q, wr_drop_d;
  logic          busy;
  logic          wr_ok;

  assign busy = (state_q == SWEEP);

`ifdef REGFILE_ZERO_REG0_EN
  assign wr_ok = bus.we && !busy && (bus.waddr != '0);
`else
  assign wr_ok = bus.we && !busy;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    wr_drop_d = bus.we && busy;

    if (wr_ok) begin
      mem_d[bus.waddr] = bus.wdata;
    end

    case (state_q)
      IDLE: begin
        if (bus.init_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef REGFILE_ZERO_REG0_EN
    mem_d[0] = '0;
`endif

    // Reading the next-state array gives write-first and sweep-first bypass for free.
    rdata_a_d = bus.re_a ? mem_d[bus.raddr_a] : rdata_a_q;
    rdata_b_d = bus.re_b ? mem_d[bus.raddr_b] : rdata_b_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_2r1w_sweep.sv
// tb/tb_regfile_2r1w_sweep.sv - scoreboard bench for regfile_2r1w_sweep
module tb_regfile_2r1w_sweep;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  regfile_2r1w_sweep_if #(.DW(DW), .AW(AW)) bus ();
  regfile_2r1w_sweep #(.DW(DW), .AW(AW)) dut (.clk(clk), .clr(clr), .bus(bus));

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   busy_cnt;

`ifdef REGFILE_ZERO_REG0_EN
  localparam logic [DW-1:0] REG0_EXP = 8'h00;
`else
  localparam logic [DW-1:0] REG0_EXP = 8'h99;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re_a = 1'b0; bus.raddr_a = '0;
    bus.re_b = 1'b0; bus.raddr_b = '0;
    bus.init_req = 1'b0;
  endtask

  task automatic push_rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    exp_t e;
    bus.re_a = 1'b1; bus.raddr_a = ra;
    bus.re_b = 1'b1; bus.raddr_b = rb;
    e.a = ea; e.b = eb;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_a"}, 32'(bus.rdata_a), 32'(e.a));
      chk({tag, "_b"}, 32'(bus.rdata_b), 32'(e.b));
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd2(input string tag, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    push_rd(ra, rb, ea, eb);
    tick();
    bus.re_a = 1'b0; bus.re_b = 1'b0;
    pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    clr = 1'b1;
    #2;
    chk("rst_rdata_a", 32'(bus.rdata_a), 32'h0);
    chk("rst_rdata_b", 32'(bus.rdata_b), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_wr_drop", 32'(bus.wr_drop), 32'h0);
    #10 clr = 1'b0;
    tick();

    // Basic write/read
    wr(3'd3, 8'h5A);
    chk("wr_drop_idle", 32'(bus.wr_drop), 32'h0);
    wr(3'd6, 8'hC3);
    rd2("basic_rd", 3'd3, 3'd6, 8'h5A, 8'hC3);
    rd2("unwritten", 3'd1, 3'd7, 8'h00, 8'h00);

    // Write-first bypass on both ports, then hold with re=0
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 8'h77;
    push_rd(3'd2, 3'd2, 8'h77, 8'h77);
    tick();
    drive_idle();
    pop_chk("bypass");
    bus.raddr_a = 3'd3; bus.raddr_b = 3'd6;
    sb_q.push_back('{8'h77, 8'h77});
    tick();
    pop_chk("hold");

    // Fill and sweep
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'((i + 1) * 8'h11));
    bus.init_req = 1'b1;
    tick();
    bus.init_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      busy_cnt++;
      case (c)
        0: push_rd(3'd7, 3'd0, 8'h88, 8'h00);
        1: begin bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 8'hFF; bus.init_req = 1'b1; end
        3: push_rd(3'd0, 3'd6, 8'h00, 8'h77);
        default: ;
      endcase
      tick();
      drive_idle();
      case (c)
        0: pop_chk("sweep_rd7_rd0");
        1: chk("sweep_wr_drop", 32'(bus.wr_drop), 32'h1);
        2: chk("sweep_wr_drop_off", 32'(bus.wr_drop), 32'h0);
        3: pop_chk("sweep_rd0_rd6");
        default: ;
      endcase
    end
    chk("busy_len", 32'(busy_cnt), 32'd8);
    for (int i = 0; i < 8; i += 2) rd2("post_sweep", AW'(i), AW'(i + 1), 8'h00, 8'h00);

    // Reset in the middle of a sweep
    wr(3'd1, 8'hAB);
    wr(3'd7, 8'h5E);
    bus.init_req = 1'b1;
    tick();
    bus.init_req = 1'b0;
    push_rd(3'd1, 3'd1, 8'hAB, 8'hAB);
    tick();
    drive_idle();
    pop_chk("pre_abort_rd");
    tick();
    tick();
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 8'h12;
    tick();
    drive_idle();
    chk("pre_abort_drop", 32'(bus.wr_drop), 32'h1);
    #1 clr = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_wr_drop", 32'(bus.wr_drop), 32'h0);
    chk("abort_rdata_a", 32'(bus.rdata_a), 32'h0);
    chk("abort_rdata_b", 32'(bus.rdata_b), 32'h0);
    #1 clr = 1'b0;
    tick();
    chk("abort_idle", 32'(bus.busy), 32'h0);
    wr(3'd4, 8'h3C);
    chk("abort_wr_ok", 32'(bus.wr_drop), 32'h0);
    rd2("abort_rd", 3'd4, 3'd7, 8'h3C, 8'h00);

    // Entry 0 behaviour (build dependent)
    wr(3'd0, 8'h99);
    chk("reg0_wr_drop", 32'(bus.wr_drop), 32'h0);
    rd2("reg0_rd", 3'd0, 3'd4, REG0_EXP, 8'h3C);
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'h99;
    push_rd(3'd0, 3'd0, REG0_EXP, REG0_EXP);
    tick();
    drive_idle();
    pop_chk("reg0_bypass");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
